ls74157_reader: RTL and testbench

Sequencing reader for a quad 2-to-1 multiplexer (ls74157) on the CPU datapath. On a start request it drives the mux `select` and `enable_n` lines itself and waits a programmable settle time after each select change. It samples the mux output for source A and then for source B, and presents both nibbles together with a valid/ready handshake. It also checks that the mux output reads zero while the mux is disabled, and reports a bus fault if it does not.

---
 rtl/ls74157_reader.sv | 118 +++++++++++
 tb/tb_ls74157_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ls74157_reader.sv
// Sequences select/enable on an external ls74157 quad 2:1 mux, captures source A then B, and flags a nonzero output while disabled.
// Latency: A captured at T0+1+SETTLE, B captured and out_valid raised at T0+2+2*SETTLE (T0 = edge sampling start).
// Backpressure: a completed read holds in DONE until out_ready; start is ignored everywhere except IDLE.
module ls74157_reader #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             mux_select,
    output logic             mux_enable_n,
    input  logic [WIDTH-1:0] mux_y,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bus_fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE_A = 2'd1,
        SETTLE_B = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] a_d, b_d;
    logic             valid_d, sel_d, en_n_d, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            hold_q       <= '0;
            a_out        <= '0;
            b_out        <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            mux_select   <= 1'b0;
            mux_enable_n <= 1'b1;
            bus_fault    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            a_out        <= a_d;
            b_out        <= b_d;
            out_valid    <= valid_d;
            busy         <= (state_d != IDLE);
            mux_select   <= sel_d;
            mux_enable_n <= en_n_d;
            bus_fault    <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        a_d     = a_out;
        b_d     = b_out;
        valid_d = out_valid;
        sel_d   = mux_select;
        en_n_d  = mux_enable_n;
        fault_d = bus_fault;
        case (state_q)
            IDLE: begin
                en_n_d = 1'b1;
                if (start) begin
                    // Mux is still disabled on this edge, so any nonzero output is a bus fault.
                    if (mux_y != '0) fault_d = 1'b1;
                    state_d = SETTLE_A;
                    en_n_d  = 1'b0;
                    sel_d   = 1'b0;
                    cnt_d   = SETTLE_CNT;
                end
            end
            SETTLE_A: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hold_d  = mux_y;
                    sel_d   = 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = SETTLE_B;
                end
            end
            SETTLE_B: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Publish both nibbles together so a consumer never sees a half-updated pair.
                    a_d     = hold_q;
                    b_d     = mux_y;
                    valid_d = 1'b1;
                    en_n_d  = 1'b1;
                    sel_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ls74157_reader.sv
// Directed bench for ls74157_reader with a behavioural ls74157 in front of it; SETTLE=1 and SETTLE=0 instances.
module tb_ls74157_reader;

    logic       clk;
    logic       rst_n;
    logic       start, out_ready;
    logic       start0, out_ready0;
    logic [3:0] a_src, b_src;
    logic       fault_stub;

    logic       busy, mux_select, mux_enable_n, out_valid, bus_fault;
    logic [3:0] mux_y, a_out, b_out;
    logic       busy0, mux_select0, mux_enable_n0, out_valid0, bus_fault0;
    logic [3:0] mux_y0, a_out0, b_out0;

    int n_checks = 0;
    int n_fail   = 0;

    // ls74157: outputs forced low while disabled; the stub instead drives 0011 to provoke a fault.
    assign mux_y  = mux_enable_n ? (fault_stub ? 4'b0011 : 4'b0000) : (mux_select ? b_src : a_src);
    assign mux_y0 = mux_enable_n0 ? 4'b0000 : (mux_select0 ? b_src : a_src);

    ls74157_reader #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .mux_select(mux_select), .mux_enable_n(mux_enable_n), .mux_y(mux_y),
        .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
        .out_ready(out_ready), .bus_fault(bus_fault)
    );

    ls74157_reader #(.WIDTH(4), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
        .mux_select(mux_select0), .mux_enable_n(mux_enable_n0), .mux_y(mux_y0),
        .a_out(a_out0), .b_out(b_out0), .out_valid(out_valid0),
        .out_ready(out_ready0), .bus_fault(bus_fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mux_enable_n !== 1'b1) begin n_fail++; $display("FAIL reset_en_n got %b want 1", mux_enable_n); end
        n_checks++; if (mux_select !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b want 0", mux_select); end
        n_checks++; if ({busy, out_valid, bus_fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, out_valid, bus_fault}); end
        n_checks++; if ({a_out, b_out} !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", {a_out, b_out}); end
        step(); step();
        rst_n = 1'b1;
        step();
        n_checks++; if ({busy, out_valid, mux_enable_n} !== 3'b001) begin n_fail++; $display("FAIL idle_after_reset got %b want 001", {busy, out_valid, mux_enable_n}); end
    endtask

    task automatic test_nominal();
        a_src = 4'b1010; b_src = 4'b0101;
        start = 1'b1;
        step();                         // T0
        start = 1'b0;
        n_checks++; if ({busy, mux_enable_n, mux_select} !== 3'b100) begin n_fail++; $display("FAIL nom_t0 got %b want 100", {busy, mux_enable_n, mux_select}); end
        step();                         // T0+1
        n_checks++; if (mux_select !== 1'b0) begin n_fail++; $display("FAIL nom_t1_sel got %b want 0", mux_select); end
        step();                         // T0+2: A captured
        n_checks++; if (mux_select !== 1'b1) begin n_fail++; $display("FAIL nom_t2_sel got %b want 1", mux_select); end
        a_src = 4'b0000;                // A must come from the hold register now
        step();                         // T0+3
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nom_t3_valid got %b want 0", out_valid); end
        step();                         // T0+4
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nom_t4_valid got %b want 1", out_valid); end
        n_checks++; if (a_out !== 4'b1010) begin n_fail++; $display("FAIL nom_a got %b want 1010", a_out); end
        n_checks++; if (b_out !== 4'b0101) begin n_fail++; $display("FAIL nom_b got %b want 0101", b_out); end
        n_checks++; if ({busy, mux_enable_n, mux_select} !== 3'b110) begin n_fail++; $display("FAIL nom_done_ctl got %b want 110", {busy, mux_enable_n, mux_select}); end
    endtask

    task automatic test_handshake_hold();
        a_src = 4'b1111; b_src = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if ({out_valid, a_out, b_out} !== 9'b1_1010_0101) begin n_fail++; $display("FAIL hold_cyc%0d got %b want 101010101", i, {out_valid, a_out, b_out}); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if ({out_valid, busy, mux_enable_n} !== 3'b001) begin n_fail++; $display("FAIL release_ctl got %b want 001", {out_valid, busy, mux_enable_n}); end
        n_checks++; if ({a_out, b_out} !== 8'b1010_0101) begin n_fail++; $display("FAIL release_data got %b want 10100101", {a_out, b_out}); end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        logic prev;
        a_src = 4'b0011; b_src = 4'b1100;
        prev = 1'b0;
        start = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 29; c++) begin
            step();
            if (out_valid && !prev) rises.push_back(c);
            prev = out_valid;
        end
        start = 1'b0;
        step();
        out_ready = 1'b0;
        n_checks++; if (rises.size() != 5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", rises.size()); end
        foreach (rises[k]) begin
            n_checks++; if (rises[k] != 4 + 6 * k) begin n_fail++; $display("FAIL b2b_edge%0d got %0d want %0d", k, rises[k], 4 + 6 * k); end
        end
        n_checks++; if ({busy, out_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got %b want 00", {busy, out_valid}); end
        n_checks++; if ({a_out, b_out} !== 8'b0011_1100) begin n_fail++; $display("FAIL b2b_data got %b want 00111100", {a_out, b_out}); end
    endtask

    task automatic test_fault();
        fault_stub = 1'b1;
        a_src = 4'b0001; b_src = 4'b0010;
        step();
        n_checks++; if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL fault_pre got %b want 0", bus_fault); end
        start = 1'b1;
        step();                         // T0
        start = 1'b0;
        n_checks++; if (bus_fault !== 1'b1) begin n_fail++; $display("FAIL fault_t0 got %b want 1", bus_fault); end
        repeat (4) step();
        n_checks++; if ({out_valid, a_out, b_out} !== 9'b1_0001_0010) begin n_fail++; $display("FAIL fault_read got %b want 100010010", {out_valid, a_out, b_out}); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (2) step();
        n_checks++; if ({bus_fault, busy} !== 2'b10) begin n_fail++; $display("FAIL fault_sticky got %b want 10", {bus_fault, busy}); end
        fault_stub = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_src = 4'b1001; b_src = 4'b0110;
        start = 1'b1;
        step();                         // T0
        start = 1'b0;
        repeat (3) step();              // T0+3: one cycle into SETTLE_B
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mux_enable_n, mux_select, out_valid, busy} !== 4'b1000) begin n_fail++; $display("FAIL midrst_ctl got %b want 1000", {mux_enable_n, mux_select, out_valid, busy}); end
        n_checks++; if ({a_out, b_out} !== 8'h00) begin n_fail++; $display("FAIL midrst_data got %h want 00", {a_out, b_out}); end
        n_checks++; if (bus_fault !== 1'b0) begin n_fail++; $display("FAIL midrst_fault got %b want 0", bus_fault); end
        step();
        rst_n = 1'b1;
        a_src = 4'b1111; b_src = 4'b0000;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        n_checks++; if ({out_valid, a_out, b_out} !== 9'b1_1111_0000) begin n_fail++; $display("FAIL restart_read got %b want 111110000", {out_valid, a_out, b_out}); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_settle0();
        a_src = 4'b0110; b_src = 4'b1001;
        start0 = 1'b1;
        step();                         // T0
        start0 = 1'b0;
        n_checks++; if ({busy0, mux_enable_n0, mux_select0} !== 3'b100) begin n_fail++; $display("FAIL s0_t0 got %b want 100", {busy0, mux_enable_n0, mux_select0}); end
        step();                         // T0+1: A captured
        n_checks++; if ({out_valid0, mux_select0} !== 2'b01) begin n_fail++; $display("FAIL s0_t1 got %b want 01", {out_valid0, mux_select0}); end
        step();                         // T0+2
        n_checks++; if ({out_valid0, a_out0, b_out0} !== 9'b1_0110_1001) begin n_fail++; $display("FAIL s0_read got %b want 101101001", {out_valid0, a_out0, b_out0}); end
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        n_checks++; if ({out_valid0, busy0, bus_fault0} !== 3'b000) begin n_fail++; $display("FAIL s0_release got %b want 000", {out_valid0, busy0, bus_fault0}); end
    endtask

    initial begin
        start = 1'b0; out_ready = 1'b0;
        start0 = 1'b0; out_ready0 = 1'b0;
        a_src = 4'b0000; b_src = 4'b0000;
        fault_stub = 1'b0;
        test_reset();
        test_nominal();
        test_handshake_hold();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        test_settle0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
